// File: rtl/branch_pkg.sv
// Shared encodings for the UAZ branch unit: branch opcodes and COND field layout.
package branch_pkg;

  typedef enum logic [1:0] {
    OP_JMP    = 2'b00,
    OP_CALL   = 2'b01,
    OP_RET    = 2'b10,
    OP_CLRERR = 2'b11
  } br_op_e;

  localparam int unsigned COND_INV_BIT = 3;
  localparam int unsigned COND_SRC_MSB = 2;
  localparam int unsigned COND_SRC_LSB = 0;

  localparam logic [3:0] COND_ALWAYS = 4'b0000;
  localparam logic [3:0] COND_NEVER  = 4'b1000;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO with saturating occupancy counter; push/pop are ignored
// when they would overflow or underflow.
module ret_stack #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] top,
  output logic [CNT_W-1:0] cnt,
  output logic             full,
  output logic             empty
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] wr_idx, rd_idx;
  logic             do_push, do_pop;

  assign full    = (cnt_q == CNT_W'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Entries occupy slots 0..cnt-1, so the next free slot is cnt and the top is cnt-1.
  assign wr_idx  = IDX_W'(cnt_q);
  assign rd_idx  = IDX_W'(cnt_q - 1'b1);
  assign top     = empty ? '0 : mem_q[rd_idx];
  assign cnt     = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push) begin
      cnt_d = cnt_q + 1'b1;
    end else if (do_pop) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (do_push) begin
        mem_q[wr_idx] <= din;
      end
    end
  end

endmodule

// File: rtl/branch_unit.sv
// Jump/branch unit: flags register, condition evaluation, JMP/CALL/RET/CLRERR
// decode and a registered one-cycle result towards the PC register.
module branch_unit
  import branch_pkg::*;
#(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned FLAG_W    = 3,
  parameter int unsigned STK_DEPTH = 4,
  parameter int unsigned SP_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [FLAG_W-1:0] flag_in,
  input  logic              flag_we,
  input  logic              br_valid,
  input  logic [1:0]        br_op,
  input  logic [3:0]        cond,
  input  logic [ADDR_W-1:0] target,
  input  logic [ADDR_W-1:0] ret_addr,
  output logic [FLAG_W-1:0] flag_out,
  output logic              br_done,
  output logic              taken,
  output logic [ADDR_W-1:0] new_pc,
  output logic [SP_W-1:0]   stk_cnt,
  output logic              stk_full,
  output logic              stk_empty,
  output logic              stk_ovf,
  output logic              stk_unf
);

  logic [FLAG_W-1:0] flags_q, flags_eff;
  logic              br_done_q, br_done_d;
  logic              taken_q, taken_d;
  logic [ADDR_W-1:0] new_pc_q, new_pc_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic [2:0]        cond_src;
  logic              cond_hit, cond_ok;
  logic              push, pop;
  logic [ADDR_W-1:0] stk_top;
  br_op_e            op;

  // A same-cycle flag write is forwarded so the branch sees the ALU's newest flags.
  assign flags_eff = flag_we ? flag_in : flags_q;
  assign cond_src  = cond[COND_SRC_MSB:COND_SRC_LSB];
  assign op        = br_op_e'(br_op);

  always_comb begin
    cond_hit = 1'b0;
    if (cond_src == '0) begin
      cond_hit = 1'b1;
    end else begin
      for (int unsigned i = 0; i < FLAG_W; i++) begin
        if (32'(cond_src) == i + 1) begin
          cond_hit = flags_eff[i];
        end
      end
    end
  end

  assign cond_ok = cond_hit ^ cond[COND_INV_BIT];

  always_comb begin
    br_done_d = br_valid;
    taken_d   = 1'b0;
    new_pc_d  = new_pc_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    push      = 1'b0;
    pop       = 1'b0;
    if (br_valid) begin
      case (op)
        OP_JMP: begin
          if (cond_ok) begin
            taken_d  = 1'b1;
            new_pc_d = target;
          end
        end
        OP_CALL: begin
          if (cond_ok) begin
            if (stk_full) begin
              ovf_d = 1'b1;
            end else begin
              push     = 1'b1;
              taken_d  = 1'b1;
              new_pc_d = target;
            end
          end
        end
        OP_RET: begin
          if (cond_ok) begin
            if (stk_empty) begin
              unf_d = 1'b1;
            end else begin
              pop      = 1'b1;
              taken_d  = 1'b1;
              new_pc_d = stk_top;
            end
          end
        end
        default: begin
          ovf_d = 1'b0;
          unf_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q   <= '0;
      br_done_q <= 1'b0;
      taken_q   <= 1'b0;
      new_pc_q  <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
    end else begin
      if (flag_we) begin
        flags_q <= flag_in;
      end
      br_done_q <= br_done_d;
      taken_q   <= taken_d;
      new_pc_q  <= new_pc_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
    end
  end

  ret_stack #(
    .DEPTH (STK_DEPTH),
    .WIDTH (ADDR_W),
    .CNT_W (SP_W)
  ) u_ret_stack (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .din   (ret_addr),
    .top   (stk_top),
    .cnt   (stk_cnt),
    .full  (stk_full),
    .empty (stk_empty)
  );

  assign flag_out = flags_q;
  assign br_done  = br_done_q;
  assign taken    = taken_q;
  assign new_pc   = new_pc_q;
  assign stk_ovf  = ovf_q;
  assign stk_unf  = unf_q;

endmodule

// File: tb/tb_branch_unit.sv
// Directed bench for branch_unit: hand-computed expectations for flags forwarding,
// condition decode, return-stack push/pop limits, sticky errors and async reset.
module tb_branch_unit;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] flag_in;
  logic       flag_we;
  logic       br_valid;
  logic [1:0] br_op;
  logic [3:0] cond;
  logic [7:0] target;
  logic [7:0] ret_addr;
  logic [2:0] flag_out;
  logic       br_done;
  logic       taken;
  logic [7:0] new_pc;
  logic [2:0] stk_cnt;
  logic       stk_full;
  logic       stk_empty;
  logic       stk_ovf;
  logic       stk_unf;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  branch_unit #(
    .ADDR_W    (8),
    .FLAG_W    (3),
    .STK_DEPTH (4),
    .SP_W      (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flag_in   (flag_in),
    .flag_we   (flag_we),
    .br_valid  (br_valid),
    .br_op     (br_op),
    .cond      (cond),
    .target    (target),
    .ret_addr  (ret_addr),
    .flag_out  (flag_out),
    .br_done   (br_done),
    .taken     (taken),
    .new_pc    (new_pc),
    .stk_cnt   (stk_cnt),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .stk_ovf   (stk_ovf),
    .stk_unf   (stk_unf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Present one request, let the edge capture it, and return 1 time unit later.
  task automatic req(input logic [1:0] op, input logic [3:0] c, input logic [7:0] tgt,
                     input logic [7:0] ra);
    br_valid = 1'b1;
    br_op    = op;
    cond     = c;
    target   = tgt;
    ret_addr = ra;
    @(posedge clk);
    #1;
    br_valid = 1'b0;
    flag_we  = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    flag_in  = '0;
    flag_we  = 1'b0;
    br_valid = 1'b0;
    br_op    = 2'b00;
    cond     = 4'b0000;
    target   = '0;
    ret_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_br_done", br_done, 0);
    check("rst_taken", taken, 0);
    check("rst_new_pc", new_pc, 8'h00);
    check("rst_flags", flag_out, 3'b000);
    check("rst_cnt", stk_cnt, 0);
    check("rst_empty", stk_empty, 1);
    rst_n = 1'b1;
    idle();

    // Reset asserted while a CALL is being requested
    req(2'b01, 4'b0000, 8'h22, 8'h05);
    check("t1_call_cnt", stk_cnt, 1);
    br_valid = 1'b1;
    br_op    = 2'b01;
    cond     = 4'b0000;
    target   = 8'h33;
    ret_addr = 8'h06;
    #2;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t1_br_done", br_done, 0);
    check("t1_cnt", stk_cnt, 0);
    check("t1_new_pc", new_pc, 8'h00);
    br_valid = 1'b0;
    rst_n    = 1'b1;
    idle();

    // Flag forwarding into a same-cycle JMP
    flag_we = 1'b1;
    flag_in = 3'b001;
    req(2'b00, 4'b0001, 8'h40, 8'h00);
    check("t2_done", br_done, 1);
    check("t2_taken", taken, 1);
    check("t2_new_pc", new_pc, 8'h40);
    check("t2_flags", flag_out, 3'b001);
    req(2'b00, 4'b1001, 8'h55, 8'h00);
    check("t2_inv_taken", taken, 0);
    check("t2_inv_pc_hold", new_pc, 8'h40);
    idle();
    check("t2_idle_done", br_done, 0);
    check("t2_idle_pc", new_pc, 8'h40);

    // Fill the stack, then overflow
    for (int i = 0; i < 4; i++) begin
      req(2'b01, 4'b0000, 8'h80, 8'd10 + 8'(i));
      check("t3_call_taken", taken, 1);
      check("t3_call_pc", new_pc, 8'h80);
      check("t3_call_cnt", stk_cnt, i + 1);
    end
    check("t3_full", stk_full, 1);
    req(2'b01, 4'b0000, 8'h90, 8'd14);
    check("t3_ovf_done", br_done, 1);
    check("t3_ovf_taken", taken, 0);
    check("t3_ovf", stk_ovf, 1);
    check("t3_ovf_cnt", stk_cnt, 4);

    // Drain back-to-back, underflow, then clear errors
    for (int i = 0; i < 4; i++) begin
      req(2'b10, 4'b0000, 8'hff, 8'h00);
      check("t4_ret_taken", taken, 1);
      check("t4_ret_pc", new_pc, 8'd13 - 8'(i));
    end
    check("t4_empty", stk_empty, 1);
    req(2'b10, 4'b0000, 8'hff, 8'h00);
    check("t4_unf_taken", taken, 0);
    check("t4_unf", stk_unf, 1);
    check("t4_ovf_sticky", stk_ovf, 1);
    check("t4_unf_cnt", stk_cnt, 0);
    req(2'b11, 4'b1000, 8'h00, 8'h00);
    check("t4_clr_done", br_done, 1);
    check("t4_clr_taken", taken, 0);
    check("t4_clr_ovf", stk_ovf, 0);
    check("t4_clr_unf", stk_unf, 0);
    check("t4_clr_cnt", stk_cnt, 0);

    // Condition source beyond FLAG_W and a high flag bit
    req(2'b00, 4'b0101, 8'h50, 8'h00);
    check("t5_src5_taken", taken, 0);
    req(2'b00, 4'b1101, 8'h51, 8'h00);
    check("t5_src5_inv_taken", taken, 1);
    check("t5_src5_inv_pc", new_pc, 8'h51);
    flag_we = 1'b1;
    flag_in = 3'b100;
    req(2'b00, 4'b0011, 8'h60, 8'h00);
    check("t5_src3_taken", taken, 1);
    check("t5_src3_pc", new_pc, 8'h60);
    req(2'b00, 4'b0010, 8'h61, 8'h00);
    check("t5_src2_taken", taken, 0);

    // Never-condition RET leaves the stack alone
    req(2'b01, 4'b0000, 8'h70, 8'h2a);
    check("t6_push_cnt", stk_cnt, 1);
    req(2'b10, 4'b1000, 8'h00, 8'h00);
    check("t6_never_done", br_done, 1);
    check("t6_never_taken", taken, 0);
    check("t6_never_cnt", stk_cnt, 1);
    req(2'b10, 4'b0000, 8'h00, 8'h00);
    check("t6_ret_pc", new_pc, 8'h2a);
    check("t6_ret_cnt", stk_cnt, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
